// File: rtl/piso_tx_if.sv
// Parallel-load / serial-out transmitter bus: word handshake on one side,
// serial line and frame status on the other.
interface piso_tx_if #(
   parameter int WIDTH = 8
) ();
   logic             ld_valid;
   logic [WIDTH-1:0] din;
   logic             ld_ready;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output ld_valid, din,
      input  ld_ready, sout, busy, done
   );

   modport slave (
      input  ld_valid, din,
      output ld_ready, sout, busy, done
   );
endinterface

// File: rtl/piso_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits, optional
// parity bit, stop bit; every bit held for BIT_CYCLES clocks, line idles high.
module piso_tx #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int BIT_CYCLES = 1,
   parameter int PARITY     = 0
) (
   input  logic     clk,
   input  logic     clrn,
   piso_tx_if.slave tx
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             par_q, par_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;

   logic accept;
   logic bit_end;
   logic last_bit;

   assign accept   = tx.ld_valid && (state_q == S_IDLE);
   assign bit_end  = (cyc_cnt_q == CW'(BIT_CYCLES - 1));
   assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));

   // State register and datapath registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         cyc_cnt_q <= '0;
         sout_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         sout_q    <= sout_d;
         done_q    <= done_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shreg_d   = tx.din;
               par_d     = (PARITY == 2) ? ~(^tx.din) : (^tx.din);
               bit_cnt_d = '0;
               cyc_cnt_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cyc_cnt_d = '0;
               state_d   = S_DATA;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cyc_cnt_d = '0;
               // Shift so the next bit to send always sits at the output end.
               shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
               if (last_bit) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               cyc_cnt_d = cyc_cnt_q + CW'(1);
            end
         end
         S_PAR: begin
            if (bit_end) begin
               cyc_cnt_d = '0;
               state_d   = S_STOP;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cyc_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            shreg_d   = '0;
            par_d     = 1'b0;
            bit_cnt_d = '0;
            cyc_cnt_d = '0;
         end
      endcase
   end

   // Outputs decode the upcoming state so sout changes on the same edge as it.
   always_comb begin
      sout_d = 1'b1;
      done_d = (state_q == S_STOP) && bit_end;
      case (state_d)
         S_START: sout_d = 1'b0;
         S_DATA:  sout_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
         S_PAR:   sout_d = par_d;
         default: sout_d = 1'b1;
      endcase
   end

   assign tx.ld_ready = (state_q == S_IDLE);
   assign tx.busy     = (state_q != S_IDLE);
   assign tx.sout     = sout_q;
   assign tx.done     = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: four differently configured instances, a
// frame-level reference model feeding queues, and one cycle-by-cycle monitor.
module tb_piso_tx;

   localparam int NI = 4;

   function automatic int cw(input int k);
      return (k == 3) ? 5 : 8;
   endfunction

   function automatic int cm(input int k);
      return (k == 1 || k == 2) ? 0 : 1;
   endfunction

   function automatic int cbc(input int k);
      return (k == 1) ? 4 : (k == 3) ? 3 : 1;
   endfunction

   function automatic int cp(input int k);
      return (k == 2) ? 1 : (k == 3) ? 2 : 0;
   endfunction

   function automatic int flen(input int k);
      return cw(k) + 2 + ((cp(k) != 0) ? 1 : 0);
   endfunction

   // Expected line bits of a whole frame, bit 0 sent first.
   function automatic bit [31:0] frame_of(input int k, input logic [15:0] d);
      bit [31:0] f;
      int        n;
      int        ones;
      f    = '1;
      f[0] = 1'b0;
      n    = 1;
      for (int i = 0; i < cw(k); i++) begin
         f[n] = (cm(k) != 0) ? d[cw(k) - 1 - i] : d[i];
         n++;
      end
      if (cp(k) != 0) begin
         ones = $countones(d);
         f[n] = (cp(k) == 1) ? bit'(ones % 2) : bit'(1 - (ones % 2));
         n++;
      end
      f[n] = 1'b1;
      return f;
   endfunction

   logic        clk;
   logic        clrn_a [NI];
   logic        ldv_a  [NI];
   logic [15:0] din_a  [NI];
   logic        rdy_a  [NI];
   logic        sout_a [NI];
   logic        busy_a [NI];
   logic        done_a [NI];

   bit [31:0]   exp_q [NI][$];
   bit [31:0]   cur   [NI];
   int          pos   [NI];
   int          errors = 0;
   int          checks = 0;
   bit          finish_req = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         localparam int W = cw(gi);
         piso_tx_if #(.WIDTH(W)) bus ();
         piso_tx #(
            .WIDTH      (W),
            .MSB_FIRST  (cm(gi)),
            .BIT_CYCLES (cbc(gi)),
            .PARITY     (cp(gi))
         ) dut (
            .clk  (clk),
            .clrn (clrn_a[gi]),
            .tx   (bus)
         );
         assign bus.ld_valid = ldv_a[gi];
         assign bus.din      = din_a[gi][W-1:0];
         assign rdy_a[gi]    = bus.ld_ready;
         assign sout_a[gi]   = bus.sout;
         assign busy_a[gi]   = bus.busy;
         assign done_a[gi]   = bus.done;
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive_now(input int k, input bit v, input logic [15:0] d);
      logic [15:0] m;
      ldv_a[k] = v;
      din_a[k] = d;
      if (v && rdy_a[k] === 1'b1) begin
         m = d & 16'((32'd1 << cw(k)) - 1);
         exp_q[k].push_back(frame_of(k, m));
      end
   endtask

   task automatic drive_cycle(input int k, input bit v, input logic [15:0] d);
      @(negedge clk);
      #1;
      drive_now(k, v, d);
   endtask

   task automatic idle(input int k, input int n);
      for (int i = 0; i < n; i++) drive_cycle(k, 1'b0, 16'($urandom));
   endtask

   task automatic held(input int k, input int n);
      for (int i = 0; i < n; i++) drive_cycle(k, 1'b1, 16'($urandom));
   endtask

   task automatic rand_traffic(input int k, input int n);
      for (int i = 0; i < n; i++)
         drive_cycle(k, ($urandom_range(0, 3) == 0), 16'($urandom));
   endtask

   // Stimulus
   initial begin
      for (int k = 0; k < NI; k++) begin
         clrn_a[k] = 1'b0;
         ldv_a[k]  = 1'b0;
         din_a[k]  = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < NI; k++) clrn_a[k] = 1'b1;

      // Instance 0: MSB first, one clock per bit, no parity.
      drive_cycle(0, 1'b1, 16'h00A5);
      idle(0, 12);
      held(0, 25);
      idle(0, 20);
      drive_cycle(0, 1'b1, 16'($urandom));
      @(posedge clk);
      #1 ldv_a[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1 clrn_a[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      clrn_a[0] = 1'b1;
      drive_now(0, 1'b1, 16'($urandom));
      idle(0, 12);
      rand_traffic(0, 150);

      // Instance 1: LSB first, four clocks per bit.
      drive_cycle(1, 1'b1, 16'h00FF);
      idle(1, 45);
      held(1, 90);
      rand_traffic(1, 200);

      // Instance 2: LSB first, even parity.
      drive_cycle(2, 1'b1, 16'h0001);
      idle(2, 12);
      rand_traffic(2, 150);

      // Instance 3: 5-bit MSB first, three clocks per bit, odd parity.
      drive_cycle(3, 1'b1, 16'h0001);
      idle(3, 25);
      held(3, 60);
      rand_traffic(3, 200);

      for (int k = 0; k < NI; k++) ldv_a[k] = 1'b0;
      repeat (60) @(negedge clk);
      #1 finish_req = 1'b1;
   end

   // Monitor: compares {sout,busy,done,ld_ready} of every instance each cycle.
   initial begin
      int cyc;
      cyc = 0;
      for (int k = 0; k < NI; k++) pos[k] = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (finish_req) begin
            for (int k = 0; k < NI; k++) begin
               checks++;
               if (exp_q[k].size() != 0 || pos[k] >= 0) begin
                  errors++;
                  $display("FAIL inst%0d drain: pending=%0d in_frame_pos=%0d, want pending=0 pos=-1",
                           k, exp_q[k].size(), pos[k]);
               end
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         if (cyc > 20000) begin
            errors++;
            checks++;
            $display("FAIL timeout: cycle %0d reached, want stimulus finished", cyc);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         for (int k = 0; k < NI; k++) begin
            int         blen;
            logic [3:0] want;
            logic [3:0] got;
            blen = flen(k) * cbc(k);
            if (clrn_a[k] !== 1'b1) begin
               pos[k] = -1;
            end else if (pos[k] < 0 && busy_a[k] === 1'b1 && exp_q[k].size() > 0) begin
               cur[k] = exp_q[k].pop_front();
               pos[k] = 0;
            end
            if (clrn_a[k] === 1'b1 && pos[k] >= 0)
               want = (pos[k] < blen) ? {cur[k][pos[k] / cbc(k)], 3'b100} : 4'b1011;
            else
               want = 4'b1001;
            got = {sout_a[k], busy_a[k], done_a[k], rdy_a[k]};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL inst%0d cycle %0d frame_pos %0d: {sout,busy,done,ready} got %b want %b",
                        k, cyc, pos[k], got, want);
            end
            if (pos[k] >= blen) pos[k] = -1;
            else if (pos[k] >= 0) pos[k]++;
         end
      end
   end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per frame (range 1..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 sends din[WIDTH-1] first and 0 sends din[0] first.
REQ-003 The block SHALL have parameter BIT_CYCLES, default 1, giving clocks per serial bit (range 1..255).
REQ-004 The block SHALL have parameter PARITY, default 0, where 0 means no parity bit, 1 means even parity and 2 means odd parity.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port clrn, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port ld_valid, input, 1 bit: parallel word offered.
REQ-008 The block SHALL have port din, input, WIDTH bits: parallel word, sampled only on accept.
REQ-009 The block SHALL have port ld_ready, output, 1 bit: block can accept a word.
REQ-010 The block SHALL have port sout, output, 1 bit: serial line, registered, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 The block SHALL implement the states IDLE, START, DATA, PAR and STOP.
REQ-014 The block SHALL assert ld_ready only in IDLE, and accept a word on the rising edge where ld_valid and ld_ready are both 1.
REQ-015 On accept, the block SHALL load din into an internal WIDTH-bit shift register, compute the parity bit, clear the bit counter and cycle counter, and enter START.
REQ-016 The block SHALL make sout a registered decode of state and data: 1 in IDLE, 0 in START, the current data bit in DATA, the parity bit in PAR, and 1 in STOP.
REQ-017 The block SHALL hold each state's bit for exactly BIT_CYCLES clocks, counted by a cycle counter that wraps to 0 when the bit advances.
REQ-018 The block SHALL sequence START -> DATA -> PAR (PARITY!=0 only) -> STOP -> IDLE; DATA SHALL last WIDTH bits, shifting once per bit in the MSB_FIRST direction.
REQ-019 The block SHALL compute the parity bit as XOR of all data bits for PARITY=1, and as its inverse for PARITY=2.
REQ-020 Frame length SHALL be (WIDTH+2+(PARITY!=0))*BIT_CYCLES clocks, from the accept edge to the edge that returns the block to IDLE.
REQ-021 The block SHALL have busy=1 in START, DATA, PAR and STOP, and busy=0 in IDLE.
REQ-022 The block SHALL assert done for exactly the first IDLE cycle after STOP; ld_ready SHALL also be 1 in that cycle, so a held ld_valid gives back-to-back frames separated by one idle-high cycle.
REQ-023 The block SHALL ignore ld_valid and din while busy, with no effect on the frame in progress.
REQ-024 The block SHALL not leave IDLE on ld_valid=0.
REQ-025 The block SHALL fully define encoding of unused states and recover to IDLE with sout=1 on the next edge.

Reset
REQ-026 When clrn=0, the block SHALL, asynchronously and independent of clk, force state=IDLE, sout=1, busy=0, done=0, ld_ready=1, and clear the shift register and counters.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done pulse, and SHALL not cause a spurious low glitch on sout.
REQ-028 After clrn rises, the block SHALL accept a word on the first edge with ld_valid=1.

Verification
REQ-029 With WIDTH=8, MSB_FIRST=1, BIT_CYCLES=1 and PARITY=0, accepting din=8'hA5 SHALL give sout=0,1,0,1,0,0,1,0,1,1 on successive cycles, then done=1 for one cycle with sout=1.
REQ-030 With MSB_FIRST=0, PARITY=1 and din=8'h01, sout SHALL be 0,1,0,0,0,0,0,0,0,1(parity),1(stop); with PARITY=2 the parity bit SHALL be 0.
REQ-031 With BIT_CYCLES=4 and din=8'hFF, the start bit SHALL be low for exactly 4 clocks and the frame SHALL be 40 clocks long with busy=1 throughout.
REQ-032 With ld_valid held high and din changed during the frame, the first frame SHALL carry the accepted word, there SHALL be exactly one idle cycle with done=1, and the next frame SHALL carry din as sampled at that cycle.
REQ-033 With clrn pulsed low during the 4th data bit, sout SHALL be 1, busy 0 and ld_ready 1 immediately without a clock edge, with no done pulse, and a new word SHALL be accepted after release.
REQ-034 With ld_valid=0 for 20 cycles, sout SHALL be 1, busy 0 and done 0 throughout.
